// File: rtl/button_pio_irq_pkg.sv
// Shared definitions for the pushbutton PIO: register map, edge-mode encodings,
// debounce channel state type and a width helper.
package button_pio_irq_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } deb_state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/button_pio_irq_if.sv
// Avalon-MM slave bus bundle for the pushbutton PIO register file.
interface button_pio_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/button_debounce_channel.sv
// One input channel: synchroniser, INIT/RUN debounce state machine and
// registered one-cycle rise/fall pulses aligned with the level change.
module button_debounce_channel
    import button_pio_irq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sample;
    logic                   prev_reg;

    deb_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          level_reg, level_next;
    logic          rise_reg, rise_next;
    logic          fall_reg, fall_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            prev_reg <= sample;
        end
    end

    assign sample = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // INIT waits for the input to settle at any level; RUN only counts
    // cycles where the sample disagrees with the accepted level.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (sample != prev_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    level_next = sample;
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (sample == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    level_next = ~level_reg;
                    cnt_next   = '0;
                    rise_next  = sample;
                    fall_next  = ~sample;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/button_pio_irq.sv
// Avalon-MM input PIO: WIDTH debounced channels, sticky edge capture with
// write-one-to-clear, maskable registered level interrupt.
module button_pio_irq
    import button_pio_irq_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = EDGE_FALLING
) (
    input  logic                clk,
    input  logic                reset,
    button_pio_irq_if.slave     bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] w1c;

    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic             irq_reg, irq_next;
    logic [31:0]      readdata_reg, readdata_next;
    logic [31:0]      rd_mux;

    // Only one of rise/fall is consumed in the single-edge modes, and the
    // write bus is wider than the channel count.
    logic unused_bits;
    assign unused_bits = ^{rise, fall, bus.writedata};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            button_debounce_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .raw   (in_port[gi]),
                .level (level[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi])
            );

            if (EDGE_MODE == EDGE_RISING) begin : g_rise
                assign edge_hit[gi] = rise[gi];
            end else if (EDGE_MODE == EDGE_FALLING) begin : g_fall
                assign edge_hit[gi] = fall[gi];
            end else begin : g_any
                assign edge_hit[gi] = rise[gi] | fall[gi];
            end

            // A new edge outranks a simultaneous clear of the same bit.
            assign cap_next[gi] = edge_hit[gi] | (cap_reg[gi] & ~w1c[gi]);
        end
    endgenerate

    assign wr_en = bus.chipselect & bus.write;
    assign rd_en = bus.chipselect & bus.read;

    always_comb begin
        w1c       = '0;
        mask_next = mask_reg;
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            w1c = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            mask_next = bus.writedata[WIDTH-1:0];
        end
    end

    assign irq_next = |(cap_reg & mask_reg);

    // Read mux sees pre-write register values, so a same-cycle write is not
    // visible until the following read.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = level;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = mask_reg;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = cap_reg;
            default:      rd_mux = '0;
        endcase
        readdata_next = rd_en ? rd_mux : readdata_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg     <= '0;
            cap_reg      <= '0;
            irq_reg      <= 1'b0;
            readdata_reg <= '0;
        end else begin
            mask_reg     <= mask_next;
            cap_reg      <= cap_next;
            irq_reg      <= irq_next;
            readdata_reg <= readdata_next;
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_button_pio_irq.sv
// Directed and random bench for button_pio_irq against a sliding-window
// behavioural model of the debounce and register rules.
module tb_button_pio_irq;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] in_port;
    logic       irq;

    button_pio_irq_if bus ();

    button_pio_irq #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .EDGE_MODE       (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: samp_q[k] is the synchronised sample seen at edge k
    // (index 0 is the post-reset value); raw_q holds inputs seen at each edge.
    logic [3:0]  raw_q[$];
    logic [3:0]  samp_q[$];
    logic [3:0]  m_st, m_run, m_fall, m_cap, m_mask;
    logic        m_irq;
    logic [31:0] m_rd;

    always @(posedge clk) begin : model
        int         k;
        logic [3:0] smp, nst, nrun, nfall, w1c;
        bit         same, diff;
        if (reset) begin
            raw_q.delete();
            samp_q.delete();
            samp_q.push_back(4'h0);
            m_st = '0; m_run = '0; m_fall = '0; m_cap = '0; m_mask = '0;
            m_irq = 1'b0; m_rd = '0;
        end else begin
            raw_q.push_back(in_port);
            smp = (raw_q.size() > S) ? raw_q[raw_q.size() - 1 - S] : 4'h0;
            samp_q.push_back(smp);
            k = samp_q.size() - 1;
            nst = m_st; nrun = m_run; nfall = '0;
            for (int i = 0; i < W; i++) begin
                if (!m_run[i]) begin
                    if (k >= D) begin
                        same = 1;
                        for (int j = k - D; j <= k; j++)
                            if (samp_q[j][i] != smp[i]) same = 0;
                        if (same) begin
                            nrun[i] = 1'b1;
                            nst[i]  = smp[i];
                        end
                    end
                end else begin
                    diff = 1;
                    for (int j = k - D + 1; j <= k; j++)
                        if (samp_q[j][i] == m_st[i]) diff = 0;
                    if (diff) begin
                        nst[i]   = ~m_st[i];
                        nfall[i] = m_st[i];
                    end
                end
            end
            if (bus.chipselect && bus.read) begin
                case (bus.address)
                    2'd0:    m_rd = {28'h0, m_st};
                    2'd2:    m_rd = {28'h0, m_mask};
                    2'd3:    m_rd = {28'h0, m_cap};
                    default: m_rd = 32'h0;
                endcase
            end
            w1c = (bus.chipselect && bus.write && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
            m_irq = |(m_cap & m_mask);
            m_cap = (m_cap & ~w1c) | m_fall;
            if (bus.chipselect && bus.write && bus.address == 2'd2)
                m_mask = bus.writedata[3:0];
            m_st = nst; m_run = nrun; m_fall = nfall;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("model_readdata", bus.readdata, m_rd);
        chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.writedata = d;
        cyc();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
        bus.address = a;
        cyc();
        d = bus.readdata;
        bus_idle();
    endtask

    initial begin
        logic [31:0] rd;
        int          r;
        int          b;
        reset = 1'b1;
        in_port = 4'hF;
        bus.address = 2'd0;
        bus.writedata = 32'h0;
        bus_idle();

        // Power-up
        repeat (3) cyc();
        chk("reset_readdata", bus.readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        bus_read(2'd0, rd);
        chk("init_data_zero", rd, 32'h0);
        repeat (8) cyc();
        bus_read(2'd0, rd);
        chk("init_data_loaded", rd, 32'hF);
        bus_read(2'd3, rd);
        chk("init_edgecap", rd, 32'h0);
        chk("init_irq", {31'h0, irq}, 32'h0);

        // Clean press: level flips on the 6th edge; a read sampled on that
        // same edge still returns the old level.
        in_port = 4'hE;
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 2'd0;
        repeat (6) cyc();
        chk("press_edge6", bus.readdata, 32'hF);
        cyc();
        chk("press_edge7", bus.readdata, 32'hE);
        bus_idle();
        repeat (13) cyc();
        bus_read(2'd3, rd);
        chk("press_edgecap", rd, 32'h1);
        chk("press_irq_masked", {31'h0, irq}, 32'h0);

        // Release: rising edge is not captured
        in_port = 4'hF;
        repeat (12) cyc();
        bus_read(2'd0, rd);
        chk("release_data", rd, 32'hF);
        bus_read(2'd3, rd);
        chk("release_edgecap", rd, 32'h1);

        // Glitch on bit1 shorter than the debounce window
        in_port = 4'hD;
        repeat (3) cyc();
        in_port = 4'hF;
        repeat (10) cyc();
        bus_read(2'd0, rd);
        chk("glitch_data", rd, 32'hF);
        bus_read(2'd3, rd);
        chk("glitch_edgecap", rd, 32'h1);

        // Interrupt via unmask, then W1C
        bus_write(2'd2, 32'h1);
        chk("unmask_irq_same", {31'h0, irq}, 32'h0);
        cyc();
        chk("unmask_irq_next", {31'h0, irq}, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("w1c_irq_same", {31'h0, irq}, 32'h1);
        cyc();
        chk("w1c_irq_next", {31'h0, irq}, 32'h0);
        bus_read(2'd3, rd);
        chk("w1c_edgecap", rd, 32'h0);

        // Set/clear race on bit2: the W1C edge is the capture edge
        in_port = 4'hB;
        repeat (6) cyc();
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        chk("race_set_wins", rd, 32'h4);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        chk("w1c_bit2", rd, 32'h0);

        // Mid-debounce reset
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        chk("mask_upper_ignored", rd, 32'hF);
        in_port = 4'h3;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        chk("midrst_readdata", bus.readdata, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        bus_read(2'd0, rd);
        chk("midrst_init_data", rd, 32'h0);
        bus_read(2'd2, rd);
        chk("midrst_mask", rd, 32'h0);
        bus_read(2'd3, rd);
        chk("midrst_edgecap", rd, 32'h0);
        repeat (8) cyc();
        bus_read(2'd0, rd);
        chk("midrst_data_loaded", rd, 32'h3);
        bus_read(2'd3, rd);
        chk("midrst_no_capture", rd, 32'h0);
        bus_read(2'd1, rd);
        chk("reserved_reads_zero", rd, 32'h0);

        // Random phase, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, 3);
                in_port[b] = ~in_port[b];
            end
            r = $urandom_range(0, 99);
            bus.chipselect = (r < 70);
            bus.read       = (r < 45) || (r >= 60 && r < 70) || (r >= 85);
            bus.write      = (r >= 40 && r < 70) || (r >= 90);
            bus.address    = 2'($urandom_range(0, 3));
            bus.writedata  = $urandom;
            cyc();
        end
        bus_idle();
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/button_pio_irq.md
Name: button_pio_irq

Overview:
Parametrised Avalon-MM input PIO for board pushbuttons and switches, replacing the single-bit, read-only button port in the Nios system.
- Synchronises and debounces WIDTH input channels.
- Captures qualifying edges per channel in a sticky register.
- Raises a maskable level interrupt to the Nios II processor.

Parameters:
WIDTH, 4, number of input channels (1..32)
SYNC_STAGES, 2, metastability flops per channel (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (>=2)
EDGE_MODE, 1, captured edge type: 0 = rising, 1 = falling, 2 = any

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  Avalon word address
chipselect  in  1  slave select
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  raw asynchronous button inputs
irq  out  1  level interrupt, active-high

Behaviour:
- One clock; every flop is reset synchronously by reset (active-high). No asynchronous reset anywhere.
- Reset values: readdata = 0, irq = 0, mask = 0, edge_capture = 0, all debounced states = 0, all counters = 0, all channels in INIT.

Register map (read latency 1 cycle: readdata updates on the clk edge after read & chipselect and holds otherwise):
- Address 0, DATA (RO): bits [WIDTH-1:0] = debounced state; upper bits read 0.
- Address 1: reserved, reads 0, writes ignored.
- Address 2, IRQMASK (RW): bits [WIDTH-1:0]; written on write & chipselect.
- Address 3, EDGECAP (R/W1C): writing 1 to bit i clears it; writing 0 has no effect.
- Bits at or above WIDTH are ignored on write and read as 0 at every address.

Per-channel debounce state machine:
- INIT:
  - Counter increments while the sync output is unchanged from the previous cycle, and restarts at 0 on any change.
  - At count DEBOUNCE_CYCLES-1: load state = sample, go to RUN, generate no edge.
  - DATA reads 0 for the channel while it is in INIT.
- RUN:
  - Counter increments while sample != state and clears to 0 whenever sample == state.
  - At count DEBOUNCE_CYCLES-1: toggle state, emit a 1-cycle change pulse, clear the counter.
- Counter width = clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Latency from a clean input step to the DATA change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.

Edge capture and interrupt:
- A change pulse whose direction matches EDGE_MODE sets edge_capture[i] on the next clk edge.
- Simultaneous set and W1C on the same bit: set wins (bit stays 1).
- irq = |(edge_capture & mask), registered, so it asserts 1 cycle after the capture bit sets.
- Writing the mask does not clear captures. Unmasking an already-captured bit raises irq 1 cycle after the write.

Boundaries:
- Glitches shorter than DEBOUNCE_CYCLES produce no DATA change and no capture.
- Reset asserted mid-debounce discards all progress; channels re-enter INIT.
- Read and write presented in the same cycle: the read returns the pre-write value.

Decomposition:
- Shared package: register address constants (ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3), EDGE_MODE encodings, and a clog2 function.
- One sub-module, button_debounce_channel: synchroniser, INIT/RUN state machine, counter, and the rise/fall pulse outputs. The top generates WIDTH instances.
- The top holds the register file, edge capture, irq, and the read mux.

Test Plan:
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_MODE=1.
- Power-up: hold in_port=4'hF through reset and for 10 cycles -> DATA reads 0 during INIT, then 4'hF; EDGECAP = 0; irq = 0.
- Clean press: after INIT, drive bit0 low for 20 cycles -> DATA = 4'hE exactly 6 cycles after the step; EDGECAP = 4'h1; irq stays 0 while mask = 0.
- Glitch rejection: pulse bit1 low for 3 cycles -> DATA stays 4'hF; EDGECAP unchanged.
- Interrupt: write IRQMASK = 4'h1 with EDGECAP = 4'h1 -> irq = 1 one cycle later. Write EDGECAP = 4'h1 -> irq = 0 one cycle after the clear lands.
- Set/clear race: time a W1C of bit2 to land on the same cycle as a new falling pulse on bit2 -> EDGECAP[2] remains 1.
- Release and mid-operation reset:
  - Release bit0 (rising) -> no capture in mode 1.
  - Assert reset mid-debounce -> all registers return to 0 and channels return to INIT.
